// File: rtl/mem_port_arbiter.sv
// Arbitrates NUM_PORTS requesters onto one memory port, fixed-priority or round-robin; issue is
// combinational, response pulses MEM_LATENCY+1 cycles after issue; req_ready stays low while busy.
module mem_port_arbiter #(
   parameter int NUM_PORTS   = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1,
   parameter int RR_MODE     = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_PORTS-1:0]        req_valid,
   output logic [NUM_PORTS-1:0]        req_ready,
   input  logic [NUM_PORTS-1:0]        req_write,
   input  logic [3*NUM_PORTS-1:0]      req_funct3,
   input  logic [ADDR_W*NUM_PORTS-1:0] req_addr,
   input  logic [DATA_W*NUM_PORTS-1:0] req_wdata,
   output logic [NUM_PORTS-1:0]        rsp_valid,
   output logic [DATA_W-1:0]           rsp_rdata,
   output logic                        mem_en,
   output logic                        mem_we,
   output logic [2:0]                  mem_funct3,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic [DATA_W-1:0]           mem_rdata,
   output logic                        busy
);

   localparam int PW = $clog2(NUM_PORTS);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t                r_state;
   logic [2:0]            r_cnt;
   logic [PW-1:0]         r_owner;
   logic [PW-1:0]         r_ptr;
   logic                  r_we;
   logic [NUM_PORTS-1:0]  r_rsp_valid;
   logic [DATA_W-1:0]     r_rsp_rdata;

   logic [PW-1:0]         w_win;
   logic                  w_found;
   logic                  w_issue;
   int                    w_idx;

   // Scan candidates from lowest to highest precedence so the highest-precedence hit is assigned last.
   always_comb begin
      w_win   = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         if (RR_MODE != 0) w_idx = (int'(r_ptr) + k) % NUM_PORTS;
         else              w_idx = k - 1;
         if (req_valid[w_idx]) begin
            w_win   = PW'(w_idx);
            w_found = 1'b1;
         end
      end
   end

   assign w_issue    = (r_state == IDLE) && w_found && !rst;
   assign req_ready  = w_issue ? (NUM_PORTS'(1) << w_win) : '0;
   assign mem_en     = w_issue;
   assign mem_we     = w_issue & req_write[w_win];
   assign mem_funct3 = w_issue ? req_funct3[w_win*3 +: 3] : '0;
   assign mem_addr   = w_issue ? req_addr[w_win*ADDR_W +: ADDR_W] : '0;
   assign mem_wdata  = w_issue ? req_wdata[w_win*DATA_W +: DATA_W] : '0;
   assign busy       = (r_state == WAIT);
   assign rsp_valid  = r_rsp_valid;
   assign rsp_rdata  = r_rsp_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_owner     <= '0;
         r_we        <= 1'b0;
         r_ptr       <= PW'(NUM_PORTS - 1);
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= '0;
         case (r_state)
            IDLE: begin
               if (w_issue) begin
                  r_owner <= w_win;
                  r_we    <= req_write[w_win];
                  r_ptr   <= w_win;
                  r_cnt   <= 3'd1;
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               // Memory data is valid in the cycle the counter reaches the latency.
               if (r_cnt == 3'(MEM_LATENCY)) begin
                  r_rsp_valid <= NUM_PORTS'(1) << r_owner;
                  r_rsp_rdata <= r_we ? '0 : mem_rdata;
                  r_state     <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of requester channels; legal range 2..4; port 0 is the data port, port 1 is the instruction port.
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 32, data width.
REQ-004 Parameter MEM_LATENCY, default 1, cycles from issue to valid mem_rdata; legal range 1..4.
REQ-005 Parameter RR_MODE, default 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 req_valid  input  NUM_PORTS  per-port request pending.
REQ-009 req_ready  output  NUM_PORTS  per-port request accepted this cycle (combinational).
REQ-010 req_write  input  NUM_PORTS  per-port 1 = store, 0 = load.
REQ-011 req_funct3  input  3*NUM_PORTS  per-port access size code, passed to memory unchanged.
REQ-012 req_addr  input  ADDR_W*NUM_PORTS  per-port address; port i in bits [i*ADDR_W +: ADDR_W].
REQ-013 req_wdata  input  DATA_W*NUM_PORTS  per-port store data, packed like req_addr.
REQ-014 rsp_valid  output  NUM_PORTS  one-cycle completion pulse to the owning port.
REQ-015 rsp_rdata  output  DATA_W  registered load data, shared by all ports.
REQ-016 mem_en, mem_we  output  1 each  memory access strobe and write enable.
REQ-017 mem_funct3  output  3; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W  fields of the issued request.
REQ-018 mem_rdata  input  DATA_W  memory read data.
REQ-019 busy  output  1  high while a transaction is outstanding (state WAIT).

Function
REQ-020 The block SHALL implement a two-state FSM: IDLE and WAIT.
REQ-021 In IDLE with any req_valid high, the block SHALL select one winner, assert req_ready for the winner only, and drive mem_en=1 with mem_we/mem_funct3/mem_addr/mem_wdata from the winner in the same cycle (issue cycle t).
REQ-022 In every cycle other than an issue cycle, mem_en and mem_we SHALL be 0; mem_addr, mem_wdata and mem_funct3 SHALL be 0 in those cycles.
REQ-023 On issue, the block SHALL register the winner index as owner and the write flag, load a latency counter with 1, and enter WAIT.
REQ-024 In WAIT, the counter SHALL increment each cycle; when it equals MEM_LATENCY (cycle t+MEM_LATENCY) the block SHALL register mem_rdata into rsp_rdata for loads (0 for stores) and return to IDLE.
REQ-025 rsp_valid[owner] SHALL be high for exactly cycle t+MEM_LATENCY+1; all other rsp_valid bits SHALL be 0.
REQ-026 rsp_rdata SHALL hold its value until the next completion.
REQ-027 A new request SHALL be issuable in the same cycle that rsp_valid pulses, giving one transaction per MEM_LATENCY+1 cycles sustained.
REQ-028 req_ready SHALL be all-zero in WAIT and while rst is high.
REQ-029 RR_MODE=0: the winner SHALL be the lowest-indexed port with req_valid high.
REQ-030 RR_MODE=1: the block SHALL keep a last-grant pointer, updated on each issue; the winner SHALL be the first valid port searching upward from pointer+1, wrapping from NUM_PORTS-1 to 0.
REQ-031 Requesters hold valid and fields until ready; a request dropped before ready SHALL not be issued and SHALL leave the pointer unchanged.
REQ-032 A port's request fields SHALL not affect memory outputs unless that port wins in the issue cycle.

Reset
REQ-033 While rst is high, the block SHALL immediately enter IDLE, clear the counter, owner, rsp_valid and rsp_rdata to 0, and drive mem_en=0 and mem_we=0.
REQ-034 While rst is high, the block SHALL set the round-robin pointer to NUM_PORTS-1 so that port 0 wins first after reset.
REQ-035 Reset during WAIT SHALL drop the in-flight transaction; no rsp_valid for it SHALL appear after reset is released.

Verification
REQ-036 Read, MEM_LATENCY=2: port 0 load addr 0x10 in cycle 0, memory drives 0xDEADBEEF in cycle 2 -> req_ready[0]=1 and mem_en=1 in cycle 0; rsp_valid[0]=1 only in cycle 3; rsp_rdata=0xDEADBEEF.
REQ-037 Store: port 1 write addr 0x20, wdata 0x12345678, funct3=010 -> in the issue cycle mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0x12345678, mem_funct3=010; rsp_valid[1] at cycle MEM_LATENCY+1; rsp_rdata=0.
REQ-038 Fixed priority: ports 0 and 1 valid in cycle 0, MEM_LATENCY=1 -> port 0 issues in cycle 0, port 1 issues in cycle 2 with rsp_valid[0] high in that same cycle.
REQ-039 Round-robin, NUM_PORTS=3, all ports valid continuously after reset -> issue order 0,1,2,0 in cycles 0, L+1, 2(L+1), 3(L+1), where L = MEM_LATENCY.
REQ-040 Reset in the WAIT cycle of a port 1 load -> busy=0 and rsp_valid=0 immediately; no pulse after release; next request with ports 0 and 1 valid grants port 0 in RR_MODE=1.
